// File: rtl/cod_gray_contador_if.sv
// cod_gray_contador_if
//   Control and data bundle for the Gray-code counter/encoder.
//   master (controller side): drives EN, UP, LOAD, INbinario;
//                             observes OUTgray, OUTbinario, VALID, WRAP, OCUPADO.
//   slave  (counter side)   : the opposite directions.
interface cod_gray_contador_if #(
  parameter int unsigned WIDTH = 4
);
  logic             EN;
  logic             UP;
  logic             LOAD;
  logic [WIDTH-1:0] INbinario;
  logic [WIDTH-1:0] OUTgray;
  logic [WIDTH-1:0] OUTbinario;
  logic             VALID;
  logic             WRAP;
  logic             OCUPADO;

  modport master (
    output EN, UP, LOAD, INbinario,
    input  OUTgray, OUTbinario, VALID, WRAP, OCUPADO
  );

  modport slave (
    input  EN, UP, LOAD, INbinario,
    output OUTgray, OUTbinario, VALID, WRAP, OCUPADO
  );
endinterface

// File: rtl/cod_gray_contador.sv
// cod_gray_contador
//   Sequential binary-to-Gray encoder and Gray-code up/down counter.
//   A binary count register is either loaded from INbinario or stepped
//   up/down; its binary value and Gray code are registered on the same edge.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active-high
//   bus  - cod_gray_contador_if.slave:
//          EN (count enable), UP (direction), LOAD (load strobe, beats EN),
//          INbinario (word to load), OUTgray / OUTbinario (registered count),
//          VALID (OUTgray updated at last edge), WRAP (last step wrapped),
//          OCUPADO (FSM in RUN)
module cod_gray_contador #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cod_gray_contador_if.slave   bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] gray_q;
  logic             valid_q;
  logic             wrap_q;
  logic             step;
  logic             wrap_d;

  // A step happens on any edge with EN high and no LOAD, in IDLE as well as
  // RUN: the IDLE->RUN edge already performs the first step.
  always_comb begin
    step   = bus.EN && !bus.LOAD;
    cnt_d  = cnt;
    wrap_d = 1'b0;
    if (bus.LOAD) begin
      cnt_d = bus.INbinario;
    end else if (bus.EN) begin
      if (bus.UP) begin
        cnt_d  = cnt + WIDTH'(1);
        wrap_d = (cnt == '1);
      end else begin
        cnt_d  = cnt - WIDTH'(1);
        wrap_d = (cnt == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      gray_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      // Gray is encoded from the next count so it is never out of step with cnt.
      gray_q  <= cnt_d ^ (cnt_d >> 1);
      valid_q <= bus.LOAD || bus.EN;
      wrap_q  <= wrap_d;
      state   <= step ? RUN : IDLE;
    end
  end

  assign bus.OUTgray    = gray_q;
  assign bus.OUTbinario = cnt;
  assign bus.VALID      = valid_q;
  assign bus.WRAP       = wrap_q;
  assign bus.OCUPADO    = (state == RUN);

endmodule

// File: doc/cod_gray_contador.md
# cod_gray_contador

Sequential binary-to-Gray encoder and Gray-code up/down counter. It is the transmit-side counterpart of the Gray-to-binary decoder already in the design. It produces registered Gray-coded values, either by encoding a loaded binary word or by stepping an internal counter. Downstream logic feeds OUTgray to the decoder, so counter steps must change exactly one bit.

## Interface

- WIDTH, 4, word width of the binary input, Gray output and internal counter (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- EN  input  1  count enable; one step per cycle while high
- UP  input  1  direction: 1 = increment, 0 = decrement (sampled only when stepping)
- LOAD  input  1  load strobe for INbinario; priority over EN
- INbinario  input  WIDTH  binary word to load
- OUTgray  output  WIDTH  registered Gray code of the internal count
- OUTbinario  output  WIDTH  registered binary value of the internal count
- VALID  output  1  one-cycle pulse: OUTgray updated at the last edge
- WRAP  output  1  one-cycle pulse: the last step wrapped the counter
- OCUPADO  output  1  high while the FSM is in RUN

## Operation

- Internal binary count register `cnt`, WIDTH bits, arithmetic modulo 2^WIDTH.
- OUTbinario = cnt (registered). OUTgray = cnt ^ (cnt >> 1), registered on the same edge as cnt. The two outputs are never out of step.
- FSM states:
  - IDLE: after reset; counter holds.
  - RUN: counter steps.
- FSM transitions, evaluated at each edge with rst=0:
  - IDLE→RUN when EN=1 and LOAD=0. The first step happens on this same edge.
  - RUN→IDLE when EN=0 or LOAD=1.
  - Otherwise the state is held.
- Priority at each edge: rst > LOAD > EN.
- LOAD=1: cnt ← INbinario, VALID←1, WRAP←0, state→IDLE.
- EN=1, LOAD=0: cnt ← cnt+1 (UP=1) or cnt−1 (UP=0), VALID←1.
- WRAP←1 only on an up step from 2^WIDTH−1 to 0, or a down step from 0 to 2^WIDTH−1.
- EN=0, LOAD=0: cnt held, VALID←0, WRAP←0.
- Flipping UP between steps is legal and takes effect on the next step.
- A LOAD with a value equal to the current cnt still pulses VALID.
- OCUPADO = (state == RUN).

## Timing

- Reset values: cnt=0, OUTgray=0, OUTbinario=0, VALID=0, WRAP=0, OCUPADO=0, state IDLE.
- Latency is one cycle. Inputs sampled at edge k appear on the outputs after edge k.
- No combinational path from any input to any output.
- Continuous EN=1 produces a new OUTgray every cycle. VALID then stays high, one pulse per cycle.
- Successive counter steps change OUTgray in exactly one bit, including across wrap-around. A LOAD may change any number of bits.
- rst asserted mid-count: at that edge all outputs go to reset values. EN/LOAD in the same cycle are ignored.
- rst held for several cycles: outputs stay at reset values.
- After rst deasserts, stepping resumes on the first edge with EN=1.

## Test plan

- Reset, then EN=1, UP=1 for 16 cycles:
  - OUTgray sequence 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
  - WRAP=1 only on the 1000→0000 step.
  - VALID=1 every cycle; OCUPADO=1 from the first edge.
- From reset, EN=1, UP=0 for one cycle: OUTgray=1000, OUTbinario=1111, WRAP=1.
- LOAD=1, INbinario=1010:
  - Next cycle OUTgray=1111, OUTbinario=1010, VALID=1, OCUPADO=0.
  - Then EN=1, UP=1 gives OUTgray=1110.
- LOAD=1 with EN=1 and INbinario=0101 in the same cycle: OUTbinario=0101 (no increment), OUTgray=0111, state IDLE.
- Count up to OUTbinario=0110, then assert rst for one cycle with EN=1:
  - All outputs go to 0.
  - The next EN cycle gives OUTgray=0001.
- Random EN/UP/LOAD for 10,000 cycles, with a scoreboard checking:
  - OUTgray == OUTbinario ^ (OUTbinario>>1).
  - Exactly one bit changes on every non-load step.
  - The decoded OUTgray equals OUTbinario.
